enc_lag3: RTL and testbench

- Encodes the closed-loop pitch delay (integer T0, fraction T0_frac in {-1,0,1}) of one subframe into the G.729 pitch index, using 1/3 resolution.
- For subframe 1 (pit_flag=0) it also computes and holds the search window T0_min/T0_max that subframe 2 uses.
- Sits directly upstream of the pitch-parity stage; that stage takes the subframe-1 index from `index`.
- All arithmetic goes through the shared saturating add/sub operator units over port pairs. The block has no adders of its own.

---
 rtl/enc_lag3.sv | 194 +++++++++++++++++++
 tb/tb_enc_lag3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/enc_lag3.sv
// 1/3-resolution pitch-lag encoder. Produces the pitch index for one subframe
// and, for the first subframe, the search window used by the second.
module enc_lag3 #(
  parameter int PIT_MIN = 20,
  parameter int PIT_MAX = 143
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] t0,
  input  logic [15:0] t0_frac,
  input  logic        pit_flag,
  output logic        done,
  output logic [15:0] index,
  output logic [15:0] t0_min,
  output logic [15:0] t0_max,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_in,
  output logic [15:0] sub_a,
  output logic [15:0] sub_b,
  input  logic [15:0] sub_in
);

  localparam logic [15:0] PMIN = 16'(PIT_MIN);
  localparam logic [15:0] PMAX = 16'(PIT_MAX);

  typedef enum logic [4:0] {
    INIT, F1, FH, F2, F3, F4, F5,
    M1, M2, M3, M4, M5,
    S1, S2, S3, S4, S5,
    DN
  } state_t;

  state_t      state, state_next;
  logic [15:0] t0_l, t0_l_next;
  logic [15:0] frac_l, frac_l_next;
  logic        pf_l, pf_l_next;
  logic [15:0] acc, acc_next;
  logic [15:0] i_reg, i_next;
  logic [15:0] index_next, t0_min_next, t0_max_next;
  logic        done_next;

  // Signed views of the subtractor result used by every comparison.
  logic sub_neg, sub_le0;
  assign sub_neg = sub_in[15];
  assign sub_le0 = sub_in[15] | (sub_in == 16'd0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    t0_l_next   = t0_l;
    frac_l_next = frac_l;
    pf_l_next   = pf_l;
    acc_next    = acc;
    i_next      = i_reg;
    index_next  = index;
    t0_min_next = t0_min;
    t0_max_next = t0_max;
    done_next   = 1'b0;
    add_a       = 16'd0;
    add_b       = 16'd0;
    sub_a       = 16'd0;
    sub_b       = 16'd0;

    unique case (state)
      INIT: if (start) begin
        t0_l_next   = t0;
        frac_l_next = t0_frac;
        pf_l_next   = pit_flag;
        state_next  = pit_flag ? S1 : F1;
      end
      F1: begin
        sub_a = t0_l; sub_b = 16'd85;
        state_next = sub_le0 ? F2 : FH;
      end
      FH: begin
        add_a = t0_l; add_b = 16'd112;
        index_next = add_in;
        state_next = M1;
      end
      F2: begin
        add_a = t0_l; add_b = t0_l;
        acc_next = add_in;
        state_next = F3;
      end
      F3: begin
        add_a = acc; add_b = t0_l;
        acc_next = add_in;
        state_next = F4;
      end
      F4: begin
        sub_a = acc; sub_b = 16'd58;
        acc_next = sub_in;
        state_next = F5;
      end
      F5: begin
        add_a = acc; add_b = frac_l;
        index_next = add_in;
        state_next = M1;
      end
      M1: begin
        sub_a = t0_l; sub_b = 16'd5;
        t0_min_next = sub_in;
        state_next = M2;
      end
      M2: begin
        sub_a = t0_min; sub_b = PMIN;
        if (sub_neg) t0_min_next = PMIN;
        state_next = M3;
      end
      M3: begin
        add_a = t0_min; add_b = 16'd9;
        t0_max_next = add_in;
        state_next = M4;
      end
      M4: begin
        // done rises here on both branches; the clamp branch still has the
        // t0_min fix-up in M5, which lands as done falls.
        sub_a = t0_max; sub_b = PMAX;
        done_next = 1'b1;
        if (!sub_le0) begin
          t0_max_next = PMAX;
          state_next  = M5;
        end else begin
          state_next = DN;
        end
      end
      M5: begin
        sub_a = PMAX; sub_b = 16'd9;
        t0_min_next = sub_in;
        state_next = DN;
      end
      S1: begin
        sub_a = t0_l; sub_b = t0_min;
        i_next = sub_in;
        state_next = S2;
      end
      S2: begin
        add_a = i_reg; add_b = i_reg;
        acc_next = add_in;
        state_next = S3;
      end
      S3: begin
        add_a = acc; add_b = i_reg;
        acc_next = add_in;
        state_next = S4;
      end
      S4: begin
        add_a = acc; add_b = 16'd2;
        acc_next = add_in;
        state_next = S5;
      end
      S5: begin
        add_a = acc; add_b = frac_l;
        index_next = add_in;
        done_next  = 1'b1;
        state_next = DN;
      end
      DN:      state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values computed before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INIT;
      t0_l   <= 16'd0;
      frac_l <= 16'd0;
      pf_l   <= 1'b0;
      acc    <= 16'd0;
      i_reg  <= 16'd0;
      index  <= 16'd0;
      t0_min <= 16'd0;
      t0_max <= 16'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      t0_l   <= t0_l_next;
      frac_l <= frac_l_next;
      pf_l   <= pf_l_next;
      acc    <= acc_next;
      i_reg  <= i_next;
      index  <= index_next;
      t0_min <= t0_min_next;
      t0_max <= t0_max_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_enc_lag3.sv
// Bench for enc_lag3: models the shared saturating operators and compares the
// encoder against the G.729 lag-encoding formulas.
module tb_enc_lag3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] t0 = 16'd0;
  logic [15:0] t0_frac = 16'd0;
  logic        pit_flag = 1'b0;
  logic        done;
  logic [15:0] index, t0_min, t0_max;
  logic [15:0] add_a, add_b, add_in, sub_a, sub_b, sub_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference window held between operations.
  int mdl_min = 0;
  int mdl_max = 0;

  enc_lag3 dut (
    .clk(clk), .reset(reset), .start(start), .t0(t0), .t0_frac(t0_frac),
    .pit_flag(pit_flag), .done(done), .index(index), .t0_min(t0_min),
    .t0_max(t0_max), .add_a(add_a), .add_b(add_b), .add_in(add_in),
    .sub_a(sub_a), .sub_b(sub_b), .sub_in(sub_in)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  always_comb add_in = sat16(int'($signed(add_a)) + int'($signed(add_b)));
  always_comb sub_in = sat16(int'($signed(sub_a)) - int'($signed(sub_b)));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation and checks latency, index, the done pulse width and
  // the window. With inject set, stray start pulses are driven while busy.
  task automatic do_op(input int t0v, input int fracv, input bit pf,
                       input bit inject);
    int exp_idx, exp_lat, lat;
    bit found;
    if (pf) begin
      exp_idx = 3 * (t0v - mdl_min) + 2 + fracv;
      exp_lat = 5;
    end else begin
      if (t0v <= 85) begin
        exp_idx = 3 * t0v - 58 + fracv;
        exp_lat = 9;
      end else begin
        exp_idx = t0v + 112;
        exp_lat = 6;
      end
      mdl_min = (t0v - 5 < 20) ? 20 : t0v - 5;
      mdl_max = mdl_min + 9;
      if (mdl_max > 143) begin
        mdl_max = 143;
        mdl_min = 134;
      end
    end
    @(negedge clk);
    start = 1'b1; t0 = 16'(t0v); t0_frac = 16'(fracv); pit_flag = pf;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && !found; c++) begin
      if (inject && c == 3) begin
        @(negedge clk);
        start = 1'b1; t0 = 16'd30; t0_frac = 16'd1; pit_flag = ~pf;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        found = 1'b1;
        lat = c;
      end
    end
    check("latency", lat, exp_lat);
    check("index", int'(index), exp_idx);
    if (inject) begin
      @(negedge clk);
      start = 1'b1; t0 = 16'd40; pit_flag = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    check("done_pulse", int'(done), 0);
    @(posedge clk);
    #1;
    check("t0_min", int'(t0_min), mdl_min);
    check("t0_max", int'(t0_max), mdl_max);
    check("idle_ops", int'(add_a | add_b | sub_a | sub_b), 0);
    if (inject) begin
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        #1 if (done) found = 1'b1;
      end
      check("ignored_start", int'(found), 0);
      check("index_hold", int'(index), exp_idx);
    end
  endtask

  initial begin
    int t0v, fv;
    bit pf, found;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", int'(done), 0);
    check("rst_index", int'(index), 0);
    check("rst_min", int'(t0_min), 0);
    check("rst_max", int'(t0_max), 0);
    @(negedge clk) reset = 1'b0;

    do_op(60, 1, 1'b0, 1'b0);
    do_op(100, 0, 1'b0, 1'b0);
    do_op(22, -1, 1'b0, 1'b0);
    do_op(141, 0, 1'b0, 1'b0);
    do_op(60, 0, 1'b0, 1'b0);
    do_op(57, -1, 1'b1, 1'b0);
    do_op(85, 0, 1'b0, 1'b0);
    do_op(86, 1, 1'b0, 1'b0);
    do_op(100, 0, 1'b0, 1'b1);

    // Reset in F3 aborts the run with no done pulse.
    @(negedge clk);
    start = 1'b1; t0 = 16'd60; t0_frac = 16'd1; pit_flag = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", int'(done), 0);
    check("abort_index", int'(index), 0);
    check("abort_min", int'(t0_min), 0);
    check("abort_max", int'(t0_max), 0);
    mdl_min = 0;
    mdl_max = 0;
    @(negedge clk) reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (done) found = 1'b1;
    end
    check("abort_no_done", int'(found), 0);

    // Randomised runs; a second subframe only follows a valid first one.
    for (int k = 0; k < 30; k++) begin
      pf = (k > 0) && ($urandom_range(0, 1) == 1);
      fv = int'($urandom_range(0, 2)) - 1;
      if (pf) t0v = int'($urandom_range(mdl_max, mdl_min));
      else    t0v = int'($urandom_range(143, 20));
      do_op(t0v, fv, pf, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
